dht_uart_reporter: RTL and testbench

Downstream consumer of the DHT sensor interface. On each data_valid pulse it captures one reading and formats it as a fixed-length ASCII line. It then transmits the line over a UART TX pin (8N1) so a host terminal can log temperature and humidity. It sits between the sensor-interface block and the board's UART/USB bridge pin.

---
 rtl/dht_uart_if.sv | 13 +
 rtl/dht_uart_reporter.sv | 218 +++++++++++++++++++++
 tb/tb_dht_uart_reporter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/dht_uart_if.sv
// One DHT reading plus its single-cycle valid strobe, from sensor interface to reporter.
`timescale 1ns/1ps
interface dht_uart_if;
  logic [7:0] T_integral;
  logic [7:0] T_decimal;
  logic [7:0] RH_integral;
  logic [7:0] RH_decimal;
  logic [7:0] Checksum;
  logic       data_valid;

  modport master (output T_integral, T_decimal, RH_integral, RH_decimal, Checksum, data_valid);
  modport slave  (input  T_integral, T_decimal, RH_integral, RH_decimal, Checksum, data_valid);
endinterface

// File: rtl/dht_uart_reporter.sv
// Captures a DHT reading and sends it as "T:ddd.f H:ddd.f\r\n" over an 8N1 UART.
// Build option CHECKSUM_FLAG_EN inserts " OK"/" ER" (checksum verdict) before CR/LF.
`timescale 1ns/1ps
module dht_uart_reporter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic      clk_50M,
  input  logic      reset,
  dht_uart_if.slave dht,
  output logic      uart_tx,
  output logic      busy,
  output logic      frame_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
`ifdef CHECKSUM_FLAG_EN
  localparam logic [4:0] LAST_CHAR = 5'd19;
`else
  localparam logic [4:0] LAST_CHAR = 5'd16;
`endif

  typedef enum logic [2:0] {IDLE, CONVERT, LOAD, START, DATA, STOP, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [4:0]    char_idx_q, char_idx_d;
  logic [2:0]    conv_cnt_q, conv_cnt_d;
  logic [19:0]   t_dd_q, t_dd_d, rh_dd_q, rh_dd_d;
  logic [7:0]    t_dec_q, t_dec_d, rh_dec_q, rh_dec_d;
  logic [7:0]    shift_q, shift_d;
  logic          uart_tx_q, uart_tx_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic [7:0]    cur_char;
`ifdef CHECKSUM_FLAG_EN
  logic          ck_ok_q, ck_ok_d;
`else
  logic          unused_checksum;
  assign unused_checksum = ^dht.Checksum;
`endif

  // One double-dabble iteration on {hundreds, tens, ones, binary}.
  function automatic logic [19:0] dd_step(input logic [19:0] s);
    logic [19:0] a;
    a = s;
    for (int i = 0; i < 3; i++)
      if (a[8+4*i +: 4] >= 4'd5) a[8+4*i +: 4] = a[8+4*i +: 4] + 4'd3;
    return {a[18:0], 1'b0};
  endfunction

  function automatic logic [7:0] frac_ascii(input logic [7:0] v);
    return (v > 8'd9) ? 8'h39 : (8'h30 + v);
  endfunction

  always_comb begin
    cur_char = 8'h0A;
    case (char_idx_q)
      5'd0:        cur_char = 8'h54;
      5'd1, 5'd9:  cur_char = 8'h3A;
      5'd2:        cur_char = {4'h3, t_dd_q[19:16]};
      5'd3:        cur_char = {4'h3, t_dd_q[15:12]};
      5'd4:        cur_char = {4'h3, t_dd_q[11:8]};
      5'd5, 5'd13: cur_char = 8'h2E;
      5'd6:        cur_char = frac_ascii(t_dec_q);
      5'd7:        cur_char = 8'h20;
      5'd8:        cur_char = 8'h48;
      5'd10:       cur_char = {4'h3, rh_dd_q[19:16]};
      5'd11:       cur_char = {4'h3, rh_dd_q[15:12]};
      5'd12:       cur_char = {4'h3, rh_dd_q[11:8]};
      5'd14:       cur_char = frac_ascii(rh_dec_q);
`ifdef CHECKSUM_FLAG_EN
      5'd15:       cur_char = 8'h20;
      5'd16:       cur_char = ck_ok_q ? 8'h4F : 8'h45;
      5'd17:       cur_char = ck_ok_q ? 8'h4B : 8'h52;
      5'd18:       cur_char = 8'h0D;
`else
      5'd15:       cur_char = 8'h0D;
`endif
      default:     cur_char = 8'h0A;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    bit_idx_d    = bit_idx_q;
    char_idx_d   = char_idx_q;
    conv_cnt_d   = conv_cnt_q;
    t_dd_d       = t_dd_q;
    rh_dd_d      = rh_dd_q;
    t_dec_d      = t_dec_q;
    rh_dec_d     = rh_dec_q;
    shift_d      = shift_q;
    uart_tx_d    = uart_tx_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
`ifdef CHECKSUM_FLAG_EN
    ck_ok_d      = ck_ok_q;
`endif
    case (state_q)
      // DONE already has busy low, so a reading arriving there is taken as well.
      IDLE, DONE: begin
        state_d = IDLE;
        if (dht.data_valid) begin
          t_dd_d     = {12'd0, dht.T_integral};
          rh_dd_d    = {12'd0, dht.RH_integral};
          t_dec_d    = dht.T_decimal;
          rh_dec_d   = dht.RH_decimal;
`ifdef CHECKSUM_FLAG_EN
          ck_ok_d    = (8'(dht.T_integral + dht.T_decimal + dht.RH_integral + dht.RH_decimal)
                        == dht.Checksum);
`endif
          conv_cnt_d = 3'd0;
          char_idx_d = 5'd0;
          busy_d     = 1'b1;
          state_d    = CONVERT;
        end
      end
      CONVERT: begin
        t_dd_d     = dd_step(t_dd_q);
        rh_dd_d    = dd_step(rh_dd_q);
        conv_cnt_d = conv_cnt_q + 3'd1;
        if (conv_cnt_q == 3'd7) state_d = LOAD;
      end
      LOAD: begin
        shift_d   = cur_char;
        uart_tx_d = 1'b0;
        bit_cnt_d = '0;
        state_d   = START;
      end
      START: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          bit_idx_d = 3'd0;
          uart_tx_d = shift_q[0];
          state_d   = DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            uart_tx_d = 1'b1;
            state_d   = STOP;
          end else begin
            shift_d   = shift_q >> 1;
            uart_tx_d = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (char_idx_q == LAST_CHAR) begin
            char_idx_d   = 5'd0;
            busy_d       = 1'b0;
            frame_done_d = 1'b1;
            state_d      = DONE;
          end else begin
            char_idx_d = char_idx_q + 5'd1;
            state_d    = LOAD;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      bit_idx_q    <= 3'd0;
      char_idx_q   <= 5'd0;
      conv_cnt_q   <= 3'd0;
      t_dd_q       <= 20'd0;
      rh_dd_q      <= 20'd0;
      t_dec_q      <= 8'd0;
      rh_dec_q     <= 8'd0;
      shift_q      <= 8'd0;
      uart_tx_q    <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef CHECKSUM_FLAG_EN
      ck_ok_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_idx_q    <= bit_idx_d;
      char_idx_q   <= char_idx_d;
      conv_cnt_q   <= conv_cnt_d;
      t_dd_q       <= t_dd_d;
      rh_dd_q      <= rh_dd_d;
      t_dec_q      <= t_dec_d;
      rh_dec_q     <= rh_dec_d;
      shift_q      <= shift_d;
      uart_tx_q    <= uart_tx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef CHECKSUM_FLAG_EN
      ck_ok_q      <= ck_ok_d;
`endif
    end
  end

  assign uart_tx    = uart_tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_dht_uart_reporter.sv
// Random and directed readings; a UART decoder compares each line with a string-level model.
`timescale 1ns/1ps
module tb_dht_uart_reporter;
  localparam int CPB    = 10;
  localparam int BUDGET = 25 * 10 * CPB + 200;

  logic clk_50M = 1'b0;
  logic reset;
  logic uart_tx, busy, frame_done;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   line_no = 0;

  byte  rx_q[$];
  int   rx_start_q[$];
  int   rx_end_q[$];
  bit   rx_bad_q[$];
  byte  exp_q[$];

  dht_uart_if bus();

  dht_uart_reporter #(.CLKS_PER_BIT(CPB)) dut (
    .clk_50M   (clk_50M),
    .reset     (reset),
    .dht       (bus),
    .uart_tx   (uart_tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #10 clk_50M = ~clk_50M;
  always @(posedge clk_50M) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Receiver: samples every cycle of a frame, flags any bit that is not stable for CPB cycles.
  initial begin : uart_rx
    logic       prev;
    logic [9:0] bits;
    bit         bad;
    int         st;
    prev = 1'b1;
    bits = '0;
    forever begin
      @(negedge clk_50M);
      if (prev === 1'b1 && uart_tx === 1'b0) begin
        st  = cyc;
        bad = 0;
        for (int b = 0; b < 10; b++)
          for (int c = 0; c < CPB; c++) begin
            if (b != 0 || c != 0) @(negedge clk_50M);
            if (c == 0) bits[b] = uart_tx;
            else if (uart_tx !== bits[b]) bad = 1;
          end
        if (bits[0] !== 1'b0 || bits[9] !== 1'b1) bad = 1;
        rx_q.push_back(byte'(bits[8:1]));
        rx_start_q.push_back(st);
        rx_end_q.push_back(cyc);
        rx_bad_q.push_back(bad);
      end
      prev = uart_tx;
    end
  end

  function automatic byte dig(input int v);
    return byte'(48 + v);
  endfunction

  task automatic build_exp(input int t, input int td, input int rh, input int rhd, input int ck);
    exp_q.delete();
    exp_q.push_back(8'h54); exp_q.push_back(8'h3A);
    exp_q.push_back(dig(t / 100)); exp_q.push_back(dig((t / 10) % 10)); exp_q.push_back(dig(t % 10));
    exp_q.push_back(8'h2E); exp_q.push_back(dig(td > 9 ? 9 : td));
    exp_q.push_back(8'h20); exp_q.push_back(8'h48); exp_q.push_back(8'h3A);
    exp_q.push_back(dig(rh / 100)); exp_q.push_back(dig((rh / 10) % 10)); exp_q.push_back(dig(rh % 10));
    exp_q.push_back(8'h2E); exp_q.push_back(dig(rhd > 9 ? 9 : rhd));
`ifdef CHECKSUM_FLAG_EN
    exp_q.push_back(8'h20);
    if (((t + td + rh + rhd) % 256) == ck) begin
      exp_q.push_back(8'h4F); exp_q.push_back(8'h4B);
    end else begin
      exp_q.push_back(8'h45); exp_q.push_back(8'h52);
    end
`endif
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
  endtask

  task automatic drive_fields(input int t, input int td, input int rh, input int rhd, input int ck);
    bus.T_integral  = 8'(t);
    bus.T_decimal   = 8'(td);
    bus.RH_integral = 8'(rh);
    bus.RH_decimal  = 8'(rhd);
    bus.Checksum    = 8'(ck);
  endtask

  task automatic scramble_fields();
    drive_fields($urandom_range(255), $urandom_range(255), $urandom_range(255),
                 $urandom_range(255), $urandom_range(255));
  endtask

  // One complete line; optionally a second reading is offered 100 bit-times in.
  task automatic run_line(input int t, input int td, input int rh, input int rhd, input int ck,
                          input bit extra);
    int base, cap, drop, n, gmax, bad_n, lat;
    bit seen;
    logic [159:0] got, want;
    build_exp(t, td, rh, rhd, ck);
    base = rx_q.size();
    @(posedge clk_50M); #1;
    drive_fields(t, td, rh, rhd, ck);
    bus.data_valid = 1'b1;
    @(posedge clk_50M); #1;
    bus.data_valid = 1'b0;
    scramble_fields();
    @(negedge clk_50M);
    cap = cyc;
    check_eq("busy_at_capture", busy, 1);
    seen = 0; drop = 0;
    for (int i = 0; i < BUDGET && !seen; i++) begin
      @(negedge clk_50M);
      bus.data_valid = (extra && i == 100 * CPB);
      if (frame_done === 1'b1) seen = 1;
      else if (busy !== 1'b1) drop++;
    end
    bus.data_valid = 1'b0;
    check_eq("frame_done_seen", seen, 1);
    check_eq("busy_at_done", busy, 0);
    check_eq("busy_held", drop, 0);
    @(negedge clk_50M);
    check_eq("frame_done_width", frame_done, 0);
    n = rx_q.size() - base;
    check_eq("char_count", n, exp_q.size());
    got = '0; want = '0; gmax = 0; bad_n = 0; lat = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      want = {want[151:0], exp_q[k]};
      if (k < n) got = {got[151:0], rx_q[base + k]};
    end
    for (int k = 0; k < n; k++) begin
      if (rx_bad_q[base + k]) bad_n++;
      if (k > 0 && rx_start_q[base + k] - rx_end_q[base + k - 1] - 1 > gmax)
        gmax = rx_start_q[base + k] - rx_end_q[base + k - 1] - 1;
    end
    if (n > 0) lat = rx_start_q[base] - cap;
    check_eq("line_text", got, want);
    check_eq("bit_timing", bad_n, 0);
    check_eq("gap_le_2", (gmax <= 2), 1);
    check_eq("start_latency_le_48", (n > 0 && lat <= 48), 1);
    line_no++;
    $display("[TB] line %0d: T=%0d.%0d RH=%0d.%0d ck=%0d chars=%0d latency=%0d gap=%0d",
             line_no, t, td, rh, rhd, ck, n, lat, gmax);
  endtask

  task automatic abort_line();
    int base, fd_n, low_n;
    bit hit;
    base = rx_q.size();
    @(posedge clk_50M); #1;
    drive_fields(99, 9, 11, 1, 120);
    bus.data_valid = 1'b1;
    @(posedge clk_50M); #1;
    bus.data_valid = 1'b0;
    hit = 0;
    for (int i = 0; i < BUDGET && !hit; i++) begin
      @(negedge clk_50M);
      if (rx_q.size() >= base + 5 && uart_tx === 1'b0) hit = 1;
    end
    check_eq("abort_reached_char5", hit, 1);
    reset = 1'b0;
    @(negedge clk_50M);
    check_eq("abort_tx_high", uart_tx, 1);
    check_eq("abort_busy_low", busy, 0);
    reset = 1'b1;
    fd_n = 0; low_n = 0;
    for (int i = 0; i < 15 * CPB; i++) begin
      @(negedge clk_50M);
      if (frame_done !== 1'b0) fd_n++;
      if (uart_tx !== 1'b1) low_n++;
    end
    check_eq("abort_no_frame_done", fd_n, 0);
    check_eq("abort_tx_idle", low_n, 0);
    $display("[TB] abort during char 5: chars before abort=%0d", rx_q.size() - base);
  endtask

  initial begin
    int t, td, rh, rhd, ck;
    reset = 1'b0;
    bus.data_valid = 1'b0;
    drive_fields(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk_50M);
    @(negedge clk_50M);
    check_eq("reset_uart_tx", uart_tx, 1);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_frame_done", frame_done, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk_50M);

    run_line(25, 3, 60, 1, 89, 0);
    run_line(255, 12, 0, 0, 0, 0);
    run_line(42, 7, 55, 9, 113, 1);
    run_line(17, 5, 88, 2, 0, 0);
    abort_line();
    run_line(31, 4, 72, 8, 115, 0);
    run_line(60, 1, 25, 3, 89, 0);
    run_line(60, 1, 25, 3, 88, 0);
    for (int r = 0; r < 4; r++) begin
      t   = $urandom_range(255);
      td  = $urandom_range(15);
      rh  = $urandom_range(255);
      rhd = $urandom_range(15);
      ck  = ($urandom_range(1) == 1) ? ((t + td + rh + rhd) % 256) : $urandom_range(255);
      run_line(t, td, rh, rhd, ck, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
